// File: rtl/scalar_mult_controller.sv
// Double-and-add sequencer for Q = k*P: seeds Q from P through the RAM transfer
// unit, then steps the point-doubling and point-addition controllers bit by bit.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start
// SCAN      | searching k_reg for its leading one, one bit per cycle
// CP0..CP3  | copying P.x / P.y into Q.x / Q.y via the scratch inner slot
// STEP      | move to the next lower bit, or finish at bit 0
// DBL_ISSUE | request Q <- 2Q
// DBL_WAIT  | waiting for the doubling to complete
// ADD_ISSUE | request Q <- P+Q
// ADD_WAIT  | waiting for the addition to complete
// DONE      | completion pulse; busy drops on the following cycle
module scalar_mult_controller #(
    parameter int KEY_W = 163
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_scalar,
    input  logic             i_interupt_add,
    input  logic             i_interupt_dbl,
    input  logic             i_interupt_transfer,
    output logic [1:0]       o_command,
    output logic             o_command_transfer,
    output logic             o_read_write_command,
    output logic [5:0]       o_read_address,
    output logic [5:0]       o_write_address,
    output logic             o_busy,
    output logic             o_interupt,
    output logic             o_point_at_infinity
);

    localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(KEY_W - 1);

    localparam logic [5:0] ADDR_PX  = 6'h03;
    localparam logic [5:0] ADDR_PY  = 6'h06;
    localparam logic [5:0] ADDR_QX  = 6'h21;
    localparam logic [5:0] ADDR_QY  = 6'h27;
    localparam logic [5:0] ADDR_SCR = 6'b001_010;

    localparam logic [1:0] CMD_NONE = 2'h0;
    localparam logic [1:0] CMD_ADD  = 2'h1;
    localparam logic [1:0] CMD_DBL  = 2'h2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_CP0,
        S_CP1,
        S_CP2,
        S_CP3,
        S_STEP,
        S_DBL_ISSUE,
        S_DBL_WAIT,
        S_ADD_ISSUE,
        S_ADD_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [KEY_W-1:0] r_k;
    logic [IDX_W-1:0] r_idx;
    logic             r_issued;
    logic [1:0]       r_command;
    logic             r_cmd_xfer;
    logic             r_rw;
    logic [5:0]       r_raddr;
    logic [5:0]       r_waddr;
    logic             r_busy;
    logic             r_interupt;
    logic             r_pai;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_idx      <= '0;
            r_issued   <= 1'b0;
            r_command  <= CMD_NONE;
            r_cmd_xfer <= 1'b0;
            r_rw       <= 1'b0;
            r_raddr    <= 6'h0;
            r_waddr    <= 6'h0;
            r_busy     <= 1'b0;
            r_interupt <= 1'b0;
            r_pai      <= 1'b0;
        end else begin
            r_command  <= CMD_NONE;
            r_cmd_xfer <= 1'b0;
            r_interupt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_k     <= i_scalar;
                        r_idx   <= IDX_MAX;
                        r_busy  <= 1'b1;
                        r_pai   <= 1'b0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_k[r_idx]) begin
                        r_issued <= 1'b0;
                        r_rw     <= 1'b0;
                        r_raddr  <= ADDR_PX;
                        r_waddr  <= ADDR_SCR;
                        r_state  <= S_CP0;
                    end else if (r_idx == '0) begin
                        r_pai      <= 1'b1;
                        r_interupt <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_CP0, S_CP1, S_CP2, S_CP3: begin
                    // A completion seen while the request pulse is still out belongs
                    // to an earlier transfer, so it is not taken.
                    if (!r_issued) begin
                        r_cmd_xfer <= 1'b1;
                        r_issued   <= 1'b1;
                    end else if (!r_cmd_xfer && i_interupt_transfer) begin
                        r_issued <= 1'b0;
                        case (r_state)
                            S_CP0: begin
                                r_rw    <= 1'b1;
                                r_raddr <= ADDR_SCR;
                                r_waddr <= ADDR_QX;
                                r_state <= S_CP1;
                            end
                            S_CP1: begin
                                r_rw    <= 1'b0;
                                r_raddr <= ADDR_PY;
                                r_waddr <= ADDR_SCR;
                                r_state <= S_CP2;
                            end
                            S_CP2: begin
                                r_rw    <= 1'b1;
                                r_raddr <= ADDR_SCR;
                                r_waddr <= ADDR_QY;
                                r_state <= S_CP3;
                            end
                            default: r_state <= S_STEP;
                        endcase
                    end
                end
                S_STEP: begin
                    if (r_idx == '0) begin
                        r_interupt <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                        r_state <= S_DBL_ISSUE;
                    end
                end
                S_DBL_ISSUE: begin
                    r_command <= CMD_DBL;
                    r_state   <= S_DBL_WAIT;
                end
                S_DBL_WAIT: begin
                    if (r_command == CMD_NONE && i_interupt_dbl)
                        r_state <= r_k[r_idx] ? S_ADD_ISSUE : S_STEP;
                end
                S_ADD_ISSUE: begin
                    r_command <= CMD_ADD;
                    r_state   <= S_ADD_WAIT;
                end
                S_ADD_WAIT: begin
                    if (r_command == CMD_NONE && i_interupt_add)
                        r_state <= S_STEP;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_command            = r_command;
    assign o_command_transfer   = r_cmd_xfer;
    assign o_read_write_command = r_rw;
    assign o_read_address       = r_raddr;
    assign o_write_address      = r_waddr;
    assign o_busy               = r_busy;
    assign o_interupt           = r_interupt;
    assign o_point_at_infinity  = r_pai;

endmodule

// File: tb/tb_scalar_mult_controller.sv
// Randomised bench for scalar_mult_controller: stub point/transfer units answer
// requests after a fixed delay, and the request stream is compared with the
// double-and-add sequence derived directly from the scalar.
module tb_scalar_mult_controller;

    localparam int KEY_W = 8;
    localparam int DLY   = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [KEY_W-1:0] scalar;
    logic             int_add  = 1'b0;
    logic             int_dbl  = 1'b0;
    logic             int_xfer = 1'b0;
    logic [1:0]       command;
    logic             cmd_xfer;
    logic             rw;
    logic [5:0]       raddr;
    logic [5:0]       waddr;
    logic             busy;
    logic             intr;
    logic             pai;

    int checks = 0;
    int errors = 0;
    int ev_q[$];
    int pend_xfer = 0;
    int pend_dbl  = 0;
    int pend_add  = 0;
    int xfer_snap = 0;
    bit noise_en     = 1'b0;
    bit same_cyc_en  = 1'b0;

    scalar_mult_controller #(.KEY_W(KEY_W)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start),
        .i_scalar            (scalar),
        .i_interupt_add      (int_add),
        .i_interupt_dbl      (int_dbl),
        .i_interupt_transfer (int_xfer),
        .o_command           (command),
        .o_command_transfer  (cmd_xfer),
        .o_read_write_command(rw),
        .o_read_address      (raddr),
        .o_write_address     (waddr),
        .o_busy              (busy),
        .o_interupt          (intr),
        .o_point_at_infinity (pai)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int xfer_code(input logic r, input logic [5:0] ra, input logic [5:0] wa);
        return int'({15'd0, 1'b1, 3'd0, r, ra, wa});
    endfunction

    // Stub downstream units: answer each request DLY cycles later, optionally
    // with an extra same-cycle pulse and random stray pulses of idle types.
    always @(posedge clk) begin
        #1;
        int_add  = 1'b0;
        int_dbl  = 1'b0;
        int_xfer = 1'b0;
        if (pend_xfer > 0) begin
            pend_xfer--;
            if (pend_xfer == 0) begin
                chk("addr_stable", xfer_code(rw, raddr, waddr), xfer_snap);
                int_xfer = 1'b1;
            end
        end
        if (pend_dbl > 0) begin
            pend_dbl--;
            if (pend_dbl == 0) int_dbl = 1'b1;
        end
        if (pend_add > 0) begin
            pend_add--;
            if (pend_add == 0) int_add = 1'b1;
        end
        if (cmd_xfer === 1'b1) begin
            chk("xfer_overlap", pend_xfer, 0);
            pend_xfer = DLY;
            xfer_snap = xfer_code(rw, raddr, waddr);
            ev_q.push_back(xfer_snap);
            if (same_cyc_en) int_xfer = 1'b1;
        end
        if (command === 2'h2) begin
            chk("dbl_overlap", pend_dbl, 0);
            pend_dbl = DLY;
            ev_q.push_back(2);
            if (same_cyc_en) int_dbl = 1'b1;
        end
        if (command === 2'h1) begin
            chk("add_overlap", pend_add, 0);
            pend_add = DLY;
            ev_q.push_back(1);
            if (same_cyc_en) int_add = 1'b1;
        end
        if (noise_en && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
                0: if (pend_add == 0) int_add = 1'b1;
                1: if (pend_dbl == 0) int_dbl = 1'b1;
                default: if (pend_xfer == 0) int_xfer = 1'b1;
            endcase
        end
    end

    task automatic run_k(input logic [KEY_W-1:0] k, input bit inject,
                         input logic [KEY_W-1:0] k2, input bit abort_add);
        int exp_q[$];
        int lead = -1;
        int lat = 0;
        int int_lat = 0;
        int busy_gaps = 0;
        int late_bad = 0;
        int n;
        bit done = 1'b0;
        bit injected = 1'b0;
        logic got_pai = 1'b0;

        for (int b = KEY_W - 1; b >= 0; b--) begin
            if (k[b] && lead < 0) lead = b;
        end
        if (lead >= 0) begin
            exp_q.push_back(xfer_code(1'b0, 6'h03, 6'h0A));
            exp_q.push_back(xfer_code(1'b1, 6'h0A, 6'h21));
            exp_q.push_back(xfer_code(1'b0, 6'h06, 6'h0A));
            exp_q.push_back(xfer_code(1'b1, 6'h0A, 6'h27));
            for (int b = lead - 1; b >= 0; b--) begin
                exp_q.push_back(2);
                if (k[b]) exp_q.push_back(1);
            end
        end

        @(negedge clk);
        ev_q.delete();
        start  = 1'b1;
        scalar = k;
        while (!done && lat < 4000) begin
            @(negedge clk);
            lat++;
            start  = 1'b0;
            scalar = KEY_W'($urandom);
            if (abort_add && command === 2'h1) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_outs", {command, cmd_xfer, rw, raddr, waddr, busy, intr, pai}, 0);
                rst = 1'b0;
                for (int c = 0; c < DLY + 8; c++) begin
                    @(negedge clk);
                    if (intr !== 1'b0 || busy !== 1'b0 || command !== 2'h0 || cmd_xfer !== 1'b0)
                        late_bad++;
                end
                chk("abort_quiet", late_bad, 0);
                return;
            end
            if (inject && !injected && command === 2'h2) begin
                start    = 1'b1;
                scalar   = k2;
                injected = 1'b1;
            end
            if (intr === 1'b1) begin
                done    = 1'b1;
                got_pai = pai;
                int_lat = lat;
            end else if (busy !== 1'b1) begin
                busy_gaps++;
            end
        end
        chk("done_timeout", done, 1);
        chk("pai", got_pai, (lead < 0));
        chk("busy_gaps", busy_gaps, 0);
        if (lead < 0) chk("zero_latency", int_lat, KEY_W + 1);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("int_single", intr, 0);
        for (int c = 0; c < DLY + 3; c++) begin
            @(negedge clk);
            if (intr !== 1'b0 || busy !== 1'b0) late_bad++;
        end
        chk("idle_quiet", late_bad, 0);
        chk("n_events", ev_q.size(), exp_q.size());
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int j = 0; j < n; j++) chk("event", ev_q[j], exp_q[j]);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        scalar = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {command, cmd_xfer, rw, raddr, waddr, busy, intr, pai}, 0);
        rst = 1'b0;

        run_k(8'h01, 1'b0, 8'h00, 1'b0);
        run_k(8'h00, 1'b0, 8'h00, 1'b0);
        run_k(8'h05, 1'b0, 8'h00, 1'b0);
        run_k(8'hFF, 1'b0, 8'h00, 1'b0);
        run_k(8'h05, 1'b1, 8'hA3, 1'b0);
        run_k(8'h03, 1'b0, 8'h00, 1'b1);
        run_k(8'h03, 1'b0, 8'h00, 1'b0);

        noise_en    = 1'b1;
        same_cyc_en = 1'b1;
        run_k(8'h00, 1'b0, 8'h00, 1'b0);
        run_k(8'h80, 1'b0, 8'h00, 1'b0);
        for (int t = 0; t < 20; t++) begin
            run_k(KEY_W'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1),
                  KEY_W'($urandom_range(0, 255)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
